// File: rtl/nw_job_scheduler_if.sv
// rtl/nw_job_scheduler_if.sv - signal bundle between nw_job_scheduler, its requesters, grid and consumer
//
// Purpose: groups the two request ports, the grid drive/return signals and the
// response channel so the scheduler exposes a single bus port.
//
// Signals:
//   req0/req1, s1_0/s2_0, s1_1/s2_1  requester -> scheduler, held until granted
//   gnt0/gnt1                        scheduler -> requester, one-cycle grant pulse
//   grid_s1/grid_s2, grid_rst        scheduler -> grid (grid_rst active-high)
//   grid_valid, grid_score           grid -> scheduler
//   rsp_valid, rsp_id, rsp_score,
//   rsp_cycles, rsp_timeout          scheduler -> consumer
//   rsp_ready                        consumer -> scheduler
//   busy                             scheduler status, high outside IDLE
//
// Modports: slave = scheduler side, master = requester/grid/consumer side.

interface nw_job_scheduler_if #(
   parameter int LENGTH    = 10,
   parameter int CWIDTH    = 2,
   parameter int SWIDTH    = 16,
   parameter int CNT_WIDTH = 16
);
   localparam int SW = LENGTH * CWIDTH;

   logic                 req0;
   logic                 req1;
   logic [SW-1:0]        s1_0;
   logic [SW-1:0]        s2_0;
   logic [SW-1:0]        s1_1;
   logic [SW-1:0]        s2_1;
   logic                 gnt0;
   logic                 gnt1;
   logic [SW-1:0]        grid_s1;
   logic [SW-1:0]        grid_s2;
   logic                 grid_rst;
   logic                 grid_valid;
   logic [SWIDTH-1:0]    grid_score;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic                 rsp_id;
   logic [SWIDTH-1:0]    rsp_score;
   logic [CNT_WIDTH-1:0] rsp_cycles;
   logic                 rsp_timeout;
   logic                 busy;

   modport slave (
      input  req0, req1, s1_0, s2_0, s1_1, s2_1,
      input  grid_valid, grid_score, rsp_ready,
      output gnt0, gnt1, grid_s1, grid_s2, grid_rst,
      output rsp_valid, rsp_id, rsp_score, rsp_cycles, rsp_timeout, busy
   );

   modport master (
      output req0, req1, s1_0, s2_0, s1_1, s2_1,
      output grid_valid, grid_score, rsp_ready,
      input  gnt0, gnt1, grid_s1, grid_s2, grid_rst,
      input  rsp_valid, rsp_id, rsp_score, rsp_cycles, rsp_timeout, busy
   );
endinterface

// File: rtl/nw_job_scheduler.sv
// rtl/nw_job_scheduler.sv - round-robin job scheduler sharing one Needleman-Wunsch grid between two requesters
//
// Purpose: grants one of two requesters (round-robin when both ask), latches
// its string pair onto the grid, holds the grid in clear, releases it, waits
// for the grid's completion flag and returns score/owner/run-cycle count over
// a valid/ready response channel. One job in flight at a time.
//
// Ports:
//   clk    clock
//   reset  synchronous, active-low
//   bus    nw_job_scheduler_if.slave (requests, grid drive/return, response)
//
// Configuration macro: NW_TIMEOUT_EN - when defined, a job still running after
// TIMEOUT cycles is aborted and reported with rsp_timeout=1; when undefined,
// rsp_timeout is constant 0 and RUN waits indefinitely.

module nw_job_scheduler #(
   parameter int LENGTH     = 10,
   parameter int CWIDTH     = 2,
   parameter int SWIDTH     = 16,
   parameter int CLR_CYCLES = 2,
   parameter int CNT_WIDTH  = 16,
   parameter int TIMEOUT    = 1024
) (
   input  logic                clk,
   input  logic                reset,
   nw_job_scheduler_if.slave   bus
);
   localparam int SW    = LENGTH * CWIDTH;
   localparam int CLR_W = $clog2(CLR_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_RESP
   } state_t;

   state_t               state_q, state_d;
   logic                 rr_ptr_q, rr_ptr_d;
   logic                 owner_q, owner_d;
   logic                 gnt0_q, gnt0_d;
   logic                 gnt1_q, gnt1_d;
   logic [SW-1:0]        s1_q, s1_d;
   logic [SW-1:0]        s2_q, s2_d;
   logic [CLR_W-1:0]     clr_cnt_q, clr_cnt_d;
   logic [CNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic                 rsp_id_q, rsp_id_d;
   logic [SWIDTH-1:0]    rsp_score_q, rsp_score_d;
   logic [CNT_WIDTH-1:0] rsp_cycles_q, rsp_cycles_d;
`ifdef NW_TIMEOUT_EN
   logic                 rsp_timeout_q, rsp_timeout_d;
`endif

   // With both requests high the favoured requester (rr_ptr) wins; a lone
   // request wins outright, which is what req1 encodes in that case.
   logic grant_id;
   assign grant_id = (bus.req0 && bus.req1) ? rr_ptr_q : bus.req1;

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      owner_d      = owner_q;
      gnt0_d       = 1'b0;
      gnt1_d       = 1'b0;
      s1_d         = s1_q;
      s2_d         = s2_q;
      clr_cnt_d    = clr_cnt_q;
      run_cnt_d    = run_cnt_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_score_d  = rsp_score_q;
      rsp_cycles_d = rsp_cycles_q;
`ifdef NW_TIMEOUT_EN
      rsp_timeout_d = rsp_timeout_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (bus.req0 || bus.req1) begin
               gnt0_d    = ~grant_id;
               gnt1_d    = grant_id;
               s1_d      = grant_id ? bus.s1_1 : bus.s1_0;
               s2_d      = grant_id ? bus.s2_1 : bus.s2_0;
               owner_d   = grant_id;
               rr_ptr_d  = ~grant_id;
               clr_cnt_d = CLR_W'(CLR_CYCLES);
               state_d   = S_CLEAR;
            end
         end

         S_CLEAR: begin
            if (clr_cnt_q != '0) begin
               clr_cnt_d = clr_cnt_q - 1'b1;
            end
            // Leave on the edge where the counter hits zero, but never while
            // the grid still shows a stale completion flag from the last job.
            if ((clr_cnt_q <= CLR_W'(1)) && !bus.grid_valid) begin
               run_cnt_d = '0;
               state_d   = S_RUN;
            end
         end

         S_RUN: begin
            if (bus.grid_valid) begin
               rsp_valid_d  = 1'b1;
               rsp_id_d     = owner_q;
               rsp_score_d  = bus.grid_score;
               rsp_cycles_d = run_cnt_q;
`ifdef NW_TIMEOUT_EN
               rsp_timeout_d = 1'b0;
`endif
               state_d      = S_RESP;
            end
`ifdef NW_TIMEOUT_EN
            else if (run_cnt_q == CNT_WIDTH'(TIMEOUT)) begin
               rsp_valid_d   = 1'b1;
               rsp_id_d      = owner_q;
               rsp_score_d   = '0;
               rsp_cycles_d  = CNT_WIDTH'(TIMEOUT);
               rsp_timeout_d = 1'b1;
               state_d       = S_RESP;
            end
`endif
            else if (run_cnt_q != '1) begin
               run_cnt_d = run_cnt_q + 1'b1;
            end
         end

         S_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         rr_ptr_q     <= 1'b0;
         owner_q      <= 1'b0;
         gnt0_q       <= 1'b0;
         gnt1_q       <= 1'b0;
         s1_q         <= '0;
         s2_q         <= '0;
         clr_cnt_q    <= '0;
         run_cnt_q    <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_score_q  <= '0;
         rsp_cycles_q <= '0;
`ifdef NW_TIMEOUT_EN
         rsp_timeout_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         owner_q      <= owner_d;
         gnt0_q       <= gnt0_d;
         gnt1_q       <= gnt1_d;
         s1_q         <= s1_d;
         s2_q         <= s2_d;
         clr_cnt_q    <= clr_cnt_d;
         run_cnt_q    <= run_cnt_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_score_q  <= rsp_score_d;
         rsp_cycles_q <= rsp_cycles_d;
`ifdef NW_TIMEOUT_EN
         rsp_timeout_q <= rsp_timeout_d;
`endif
      end
   end

   assign bus.gnt0       = gnt0_q;
   assign bus.gnt1       = gnt1_q;
   assign bus.grid_s1    = s1_q;
   assign bus.grid_s2    = s2_q;
   assign bus.grid_rst   = (state_q != S_RUN);
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_score  = rsp_score_q;
   assign bus.rsp_cycles = rsp_cycles_q;

`ifdef NW_TIMEOUT_EN
   assign bus.rsp_timeout = rsp_timeout_q;
`else
   assign bus.rsp_timeout = 1'b0;
   // Watchdog compiled out: TIMEOUT has no effect in this build.
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
`endif
endmodule

// File: tb/tb_nw_job_scheduler.sv
// tb/tb_nw_job_scheduler.sv - directed self-checking bench for nw_job_scheduler

module tb_nw_job_scheduler;
   localparam int LENGTH     = 10;
   localparam int CWIDTH     = 2;
   localparam int SWIDTH     = 16;
   localparam int CLR_CYCLES = 2;
   localparam int CNT_WIDTH  = 16;
   localparam int TIMEOUT    = 8;
   localparam int SW         = LENGTH * CWIDTH;

   localparam logic [SW-1:0] STR_A = 20'h1B2C3;
   localparam logic [SW-1:0] STR_B = 20'hA5A5A;
   localparam logic [SW-1:0] STR_C = 20'h0F0F0;
   localparam logic [SW-1:0] STR_D = 20'h36C9E;
   localparam logic [SW-1:0] STR_E = 20'hFEDCB;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   nw_job_scheduler_if #(
      .LENGTH(LENGTH), .CWIDTH(CWIDTH), .SWIDTH(SWIDTH), .CNT_WIDTH(CNT_WIDTH)
   ) bus ();

   nw_job_scheduler #(
      .LENGTH(LENGTH), .CWIDTH(CWIDTH), .SWIDTH(SWIDTH),
      .CLR_CYCLES(CLR_CYCLES), .CNT_WIDTH(CNT_WIDTH), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL global_watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset          = 1'b0;
      bus.req0       = 1'b0;
      bus.req1       = 1'b0;
      bus.grid_valid = 1'b0;
      bus.grid_score = '0;
      bus.rsp_ready  = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
   endtask

   task automatic wait_grant(output int id, output bit ok);
      id = -1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.gnt0 || bus.gnt1) begin
            ok = 1'b1;
            id = (bus.gnt0 && bus.gnt1) ? 2 : (bus.gnt1 ? 1 : 0);
            break;
         end
      end
   endtask

   // Counts grid_rst-high cycles starting at the current negedge; returns at the first RUN cycle.
   task automatic wait_run(output int rst_cycles, output bit ok);
      rst_cycles = 0;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (!bus.grid_rst) begin
            ok = 1'b1;
            break;
         end
         rst_cycles++;
         tick();
      end
   endtask

   // Grid model: completion flag rises 'delay' cycles after release.
   task automatic grid_finish(input int delay, input logic [SWIDTH-1:0] score);
      repeat (delay) tick();
      bus.grid_valid = 1'b1;
      bus.grid_score = score;
      tick();
      bus.grid_valid = 1'b0;
   endtask

   task automatic accept();
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      reset = 1'b0;
      repeat (2) tick();
      checks++; if (bus.gnt0 !== 1'b0) begin errors++; $display("FAIL reset_gnt0: got %b expected 0", bus.gnt0); end
      checks++; if (bus.gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt1: got %b expected 0", bus.gnt1); end
      checks++; if (bus.grid_rst !== 1'b1) begin errors++; $display("FAIL reset_grid_rst: got %b expected 1", bus.grid_rst); end
      checks++; if (bus.grid_s1 !== '0 || bus.grid_s2 !== '0) begin errors++; $display("FAIL reset_grid_s: got %h/%h expected 0/0", bus.grid_s1, bus.grid_s2); end
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
      checks++; if (bus.rsp_id !== 1'b0 || bus.rsp_score !== '0 || bus.rsp_cycles !== '0) begin errors++; $display("FAIL reset_rsp_fields: got id %b score %h cycles %0d expected 0/0/0", bus.rsp_id, bus.rsp_score, bus.rsp_cycles); end
      checks++; if (bus.rsp_timeout !== 1'b0) begin errors++; $display("FAIL reset_rsp_timeout: got %b expected 0", bus.rsp_timeout); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      reset = 1'b1;
   endtask

   task automatic test_single_job();
      int id; bit ok; int rc;
      do_reset();
      bus.s1_0 = STR_A; bus.s2_0 = STR_A;
      bus.req0 = 1'b1;
      wait_grant(id, ok);
      checks++; if (!ok || id != 0) begin errors++; $display("FAIL single_grant: got id %0d ok %0d expected 0 1", id, ok); end
      checks++; if (bus.grid_s1 !== STR_A || bus.grid_s2 !== STR_A) begin errors++; $display("FAIL single_strings: got %h/%h expected %h/%h", bus.grid_s1, bus.grid_s2, STR_A, STR_A); end
      bus.req0 = 1'b0;
      tick();
      checks++; if (bus.gnt0 !== 1'b0) begin errors++; $display("FAIL single_gnt_pulse: got %b expected 0", bus.gnt0); end
      wait_run(rc, ok);
      checks++; if (!ok || rc + 1 < CLR_CYCLES) begin errors++; $display("FAIL single_clear_len: got %0d ok %0d expected >=%0d", rc + 1, ok, CLR_CYCLES); end
      grid_finish(19, 16'd10);
      checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b expected 1", bus.rsp_valid); end
      checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL single_rsp_id: got %b expected 0", bus.rsp_id); end
      checks++; if (bus.rsp_score !== 16'd10) begin errors++; $display("FAIL single_rsp_score: got %0d expected 10", bus.rsp_score); end
      checks++; if (bus.rsp_cycles !== 16'd19) begin errors++; $display("FAIL single_rsp_cycles: got %0d expected 19", bus.rsp_cycles); end
      checks++; if (bus.rsp_timeout !== 1'b0) begin errors++; $display("FAIL single_rsp_timeout: got %b expected 0", bus.rsp_timeout); end
      accept();
      checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.grid_rst !== 1'b1) begin errors++; $display("FAIL single_after_accept: got valid %b busy %b grid_rst %b expected 0 0 1", bus.rsp_valid, bus.busy, bus.grid_rst); end
   endtask

   task automatic test_round_robin();
      int id; bit ok; int rc;
      logic [SWIDTH-1:0] sc;
      do_reset();
      bus.s1_0 = STR_B; bus.s2_0 = STR_C;
      bus.s1_1 = STR_D; bus.s2_1 = STR_E;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      for (int j = 0; j < 4; j++) begin
         wait_grant(id, ok);
         checks++; if (!ok || id != (j % 2)) begin errors++; $display("FAIL rr_grant_%0d: got id %0d ok %0d expected %0d", j, id, ok, j % 2); end
         checks++; if (bus.grid_s1 !== ((j % 2) ? STR_D : STR_B)) begin errors++; $display("FAIL rr_strings_%0d: got %h", j, bus.grid_s1); end
         tick();
         checks++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin errors++; $display("FAIL rr_pulse_%0d: got %b%b expected 00", j, bus.gnt0, bus.gnt1); end
         wait_run(rc, ok);
         sc = SWIDTH'(100 + j);
         grid_finish(3 + j, sc);
         checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'((j % 2)) || bus.rsp_score !== sc || bus.rsp_cycles !== CNT_WIDTH'(3 + j)) begin
            errors++; $display("FAIL rr_rsp_%0d: got valid %b id %b score %0d cycles %0d expected 1 %0d %0d %0d", j, bus.rsp_valid, bus.rsp_id, bus.rsp_score, bus.rsp_cycles, j % 2, sc, 3 + j);
         end
         accept();
      end
      bus.req0 = 1'b0; bus.req1 = 1'b0;
   endtask

   task automatic test_grid_valid_stuck();
      int id; bit ok; bit bad; int rc;
      do_reset();
      bus.s1_0 = STR_C; bus.s2_0 = STR_B;
      bus.req0 = 1'b1;
      wait_grant(id, ok);
      bus.req0 = 1'b0;
      bus.grid_valid = 1'b1;
      bad = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (bus.grid_rst !== 1'b1) bad = 1'b1;
         tick();
      end
      checks++; if (bad || bus.grid_rst !== 1'b1) begin errors++; $display("FAIL stuck_hold_clear: got grid_rst %b bad %0d expected 1 0", bus.grid_rst, bad); end
      bus.grid_valid = 1'b0;
      tick();
      checks++; if (bus.grid_rst !== 1'b0) begin errors++; $display("FAIL stuck_release: got grid_rst %b expected 0", bus.grid_rst); end
      wait_run(rc, ok);
      grid_finish(4, 16'hFFFD);
      checks++; if (bus.rsp_score !== 16'hFFFD || bus.rsp_cycles !== 16'd4) begin errors++; $display("FAIL stuck_rsp: got score %h cycles %0d expected fffd 4", bus.rsp_score, bus.rsp_cycles); end
      accept();
   endtask

   task automatic test_resp_stall();
      int id; bit ok; bit bad; int rc;
      do_reset();
      bus.s1_0 = STR_B; bus.s2_0 = STR_C;
      bus.s1_1 = STR_D; bus.s2_1 = STR_A;
      bus.req0 = 1'b1;
      wait_grant(id, ok);
      bus.req0 = 1'b0;
      wait_run(rc, ok);
      grid_finish(6, 16'h0123);
      bus.req1 = 1'b1;
      bad = 1'b0;
      for (int k = 0; k < 7; k++) begin
         if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_score !== 16'h0123 ||
             bus.rsp_cycles !== 16'd6 || bus.rsp_timeout !== 1'b0 || bus.gnt1 !== 1'b0 || bus.busy !== 1'b1) bad = 1'b1;
         tick();
      end
      checks++; if (bad) begin errors++; $display("FAIL stall_stable: got valid %b id %b score %h cycles %0d gnt1 %b expected 1 0 0123 6 0", bus.rsp_valid, bus.rsp_id, bus.rsp_score, bus.rsp_cycles, bus.gnt1); end
      accept();
      checks++; if (bus.rsp_valid !== 1'b0 || bus.gnt1 !== 1'b0) begin errors++; $display("FAIL stall_accept_cycle: got valid %b gnt1 %b expected 0 0", bus.rsp_valid, bus.gnt1); end
      tick();
      checks++; if (bus.gnt1 !== 1'b1 || bus.grid_s1 !== STR_D || bus.grid_s2 !== STR_A) begin errors++; $display("FAIL stall_next_grant: got gnt1 %b s1 %h s2 %h expected 1 %h %h", bus.gnt1, bus.grid_s1, bus.grid_s2, STR_D, STR_A); end
      bus.req1 = 1'b0;
      wait_run(rc, ok);
      grid_finish(2, 16'd7);
      checks++; if (bus.rsp_id !== 1'b1 || bus.rsp_score !== 16'd7 || bus.rsp_cycles !== 16'd2) begin errors++; $display("FAIL stall_second_rsp: got id %b score %0d cycles %0d expected 1 7 2", bus.rsp_id, bus.rsp_score, bus.rsp_cycles); end
      accept();
   endtask

   task automatic test_reset_in_run();
      int id; bit ok; bit bad; int rc;
      do_reset();
      bus.s1_1 = STR_E; bus.s2_1 = STR_D;
      bus.req1 = 1'b1;
      wait_grant(id, ok);
      checks++; if (!ok || id != 1) begin errors++; $display("FAIL rir_first_grant: got id %0d expected 1", id); end
      bus.req1 = 1'b0;
      wait_run(rc, ok);
      repeat (3) tick();
      reset = 1'b0;
      tick();
      checks++; if (bus.grid_rst !== 1'b1 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || bus.grid_s1 !== '0 || bus.grid_s2 !== '0) begin
         errors++; $display("FAIL rir_reset_values: got grid_rst %b busy %b valid %b gnt %b%b s1 %h s2 %h", bus.grid_rst, bus.busy, bus.rsp_valid, bus.gnt0, bus.gnt1, bus.grid_s1, bus.grid_s2);
      end
      reset = 1'b1;
      bus.grid_valid = 1'b1;
      bus.grid_score = 16'h5555;
      tick();
      bus.grid_valid = 1'b0;
      bad = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
         tick();
      end
      checks++; if (bad) begin errors++; $display("FAIL rir_no_response: got valid %b busy %b expected 0 0", bus.rsp_valid, bus.busy); end
      bus.req1 = 1'b1;
      wait_grant(id, ok);
      checks++; if (!ok || id != 1 || bus.grid_s1 !== STR_E) begin errors++; $display("FAIL rir_regrant: got id %0d s1 %h expected 1 %h", id, bus.grid_s1, STR_E); end
      bus.req1 = 1'b0;
      wait_run(rc, ok);
      grid_finish(5, 16'h8000);
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_score !== 16'h8000 || bus.rsp_cycles !== 16'd5) begin
         errors++; $display("FAIL rir_rsp: got valid %b id %b score %h cycles %0d expected 1 1 8000 5", bus.rsp_valid, bus.rsp_id, bus.rsp_score, bus.rsp_cycles);
      end
      accept();
   endtask

   task automatic test_timeout();
      int id; bit ok; int rc;
      do_reset();
      bus.s1_0 = STR_A; bus.s2_0 = STR_C;
      bus.req0 = 1'b1;
      wait_grant(id, ok);
      bus.req0 = 1'b0;
      wait_run(rc, ok);
`ifdef NW_TIMEOUT_EN
      begin
         int n;
         bit seen;
         n = 0;
         seen = 1'b0;
         for (int k = 0; k < 30; k++) begin
            tick();
            n++;
            if (bus.rsp_valid) begin
               seen = 1'b1;
               break;
            end
         end
         checks++; if (!seen || n != TIMEOUT + 1) begin errors++; $display("FAIL timeout_latency: got seen %0d after %0d cycles expected 1 after %0d", seen, n, TIMEOUT + 1); end
         checks++; if (bus.rsp_timeout !== 1'b1 || bus.rsp_score !== '0 || bus.rsp_cycles !== CNT_WIDTH'(TIMEOUT) || bus.rsp_id !== 1'b0) begin
            errors++; $display("FAIL timeout_rsp: got to %b score %h cycles %0d id %b expected 1 0 %0d 0", bus.rsp_timeout, bus.rsp_score, bus.rsp_cycles, bus.rsp_id, TIMEOUT);
         end
         accept();
      end
`else
      begin
         bit bad;
         bad = 1'b0;
         for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.busy !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.grid_rst !== 1'b0 || bus.rsp_timeout !== 1'b0) bad = 1'b1;
         end
         checks++; if (bad) begin errors++; $display("FAIL no_timeout_wait: got busy %b valid %b grid_rst %b expected 1 0 0", bus.busy, bus.rsp_valid, bus.grid_rst); end
      end
`endif
      do_reset();
   endtask

   initial begin
      reset          = 1'b0;
      bus.req0       = 1'b0;
      bus.req1       = 1'b0;
      bus.s1_0       = '0;
      bus.s2_0       = '0;
      bus.s1_1       = '0;
      bus.s2_1       = '0;
      bus.grid_valid = 1'b0;
      bus.grid_score = '0;
      bus.rsp_ready  = 1'b0;
      test_reset();
      test_single_job();
      test_round_robin();
      test_grid_valid_stuck();
      test_resp_stall();
      test_reset_in_run();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
